regression_host: RTL

REGRESSION_HOST -- requirements
Module: regression_host

---
 rtl/regression_host.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/regression_host.sv
// Job sequencer for the regression engine: loads N sample pairs, kicks the controller,
// then streams b1, b0 and the N error words. Define REGRESSION_HOST_CHKSUM_EN to append an error checksum word.
module regression_host #(
    parameter int N  = 8,
    parameter int W  = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wx,
    output logic [W-1:0]  mem_wy,
    output logic          start,
    input  logic          ready,
    input  logic [W-1:0]  b1_in,
    input  logic [W-1:0]  b0_in,
    output logic [AW-1:0] err_raddr,
    input  logic [W-1:0]  err_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        COEF1,
        COEF0,
        RADDR,
`ifdef REGRESSION_HOST_CHKSUM_EN
        CHKSUM,
`endif
        RDATA
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [W-1:0]  err_q;
    logic          err_fresh;
    logic [W-1:0]  err_word;
    logic          last_cnt;
`ifdef REGRESSION_HOST_CHKSUM_EN
    logic [W-1:0]  sum;
`endif

    assign last_cnt = (cnt == LAST);
    // The memory word arrives during the first RDATA cycle; it is latched then and held for stalls.
    assign err_word = err_fresh ? err_rdata : err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            err_q     <= '0;
            err_fresh <= 1'b0;
`ifdef REGRESSION_HOST_CHKSUM_EN
            sum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (last_cnt) begin
                            cnt   <= '0;
                            state <= KICK;
                        end else begin
                            cnt <= cnt + AW'(1);
                        end
                    end
                end
                KICK: begin
                    state <= WAIT_BUSY;
`ifdef REGRESSION_HOST_CHKSUM_EN
                    sum   <= '0;
`endif
                end
                WAIT_BUSY: if (!ready) state <= WAIT_DONE;
                WAIT_DONE: if (ready) state <= COEF1;
                COEF1:     if (out_ready) state <= COEF0;
                COEF0:     if (out_ready) state <= RADDR;
                RADDR: begin
                    state     <= RDATA;
                    err_fresh <= 1'b1;
                end
                RDATA: begin
                    if (err_fresh) begin
                        err_q     <= err_rdata;
                        err_fresh <= 1'b0;
                    end
                    if (out_ready) begin
`ifdef REGRESSION_HOST_CHKSUM_EN
                        sum <= sum + err_word;
`endif
                        if (last_cnt) begin
                            cnt   <= '0;
`ifdef REGRESSION_HOST_CHKSUM_EN
                            state <= CHKSUM;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt   <= cnt + AW'(1);
                            state <= RADDR;
                        end
                    end
                end
`ifdef REGRESSION_HOST_CHKSUM_EN
                CHKSUM: if (out_ready) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == LOAD);
        mem_we    = in_ready & in_valid;
        mem_addr  = in_ready ? cnt : '0;
        mem_wx    = in_ready ? in_x : '0;
        mem_wy    = in_ready ? in_y : '0;
        start     = (state == KICK);
        err_raddr = (state == RADDR || state == RDATA) ? cnt : '0;
        busy      = (state != IDLE);
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            COEF1: begin
                out_valid = 1'b1;
                out_data  = b1_in;
            end
            COEF0: begin
                out_valid = 1'b1;
                out_data  = b0_in;
            end
            RDATA: begin
                out_valid = 1'b1;
                out_data  = err_word;
`ifndef REGRESSION_HOST_CHKSUM_EN
                out_last  = last_cnt;
`endif
            end
`ifdef REGRESSION_HOST_CHKSUM_EN
            CHKSUM: begin
                out_valid = 1'b1;
                out_data  = sum;
                out_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
